z80fi_insn_recorder: RTL and testbench

- Upstream feeder of the per-instruction z80fi spec modules.
- Watches the core's machine-cycle, T-state and instruction-byte strobes.
- Accumulates one retired instruction's bytes, length, M-cycle types, T-state counts and IP before/after.
- Emits them as a single-cycle z80fi_valid packet, which every insn spec and the checker consume.

---
 rtl/z80fi_insn_recorder_pkg.sv | 26 ++
 rtl/z80fi_insn_recorder_mcycle_slot.sv | 38 +++
 rtl/z80fi_insn_recorder.sv | 195 +++++++++++++++++++
 tb/tb_z80fi_insn_recorder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80fi_insn_recorder_pkg.sv
// Shared types and constants for the z80fi instruction recorder.
// Holds the machine-cycle codes, the recorder state encoding and the fixed slot-port count.
package z80fi_insn_recorder_pkg;

  localparam int CYCLE_W   = 3;
  localparam int NUM_SLOTS = 5;
  localparam int IDX_W     = 3;
  localparam int LEN_W     = 3;

  typedef enum logic [CYCLE_W-1:0] {
    CYCLE_NONE     = 3'd0,
    CYCLE_M1       = 3'd1,
    CYCLE_RDWR_MEM = 3'd2,
    CYCLE_RDWR_IO  = 3'd3,
    CYCLE_INTACK   = 3'd4,
    CYCLE_NMI      = 3'd5,
    CYCLE_BUSREQ   = 3'd6,
    CYCLE_INTERNAL = 3'd7
  } cycle_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rec_state_t;

endpackage

// File: rtl/z80fi_insn_recorder_mcycle_slot.sv
// One M-cycle slot: cycle type plus a saturating T-state counter.
// tcount_upd is the count including this clock's tick, so a closing packet can capture it.
module z80fi_insn_recorder_mcycle_slot
  import z80fi_insn_recorder_pkg::*;
#(
  parameter int TC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic               tick,
  input  logic [CYCLE_W-1:0] type_in,
  output logic [CYCLE_W-1:0] slot_type,
  output logic [TC_W-1:0]    tcount_upd
);

  logic [TC_W-1:0] tcount;

  assign tcount_upd = (tick && !(&tcount)) ? tcount + 1'b1 : tcount;

  // load beats clear: a new instruction may open on the same clock the old one closes
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_type <= CYCLE_NONE;
      tcount    <= '0;
    end else if (load) begin
      slot_type <= type_in;
      tcount    <= '0;
    end else if (clear) begin
      slot_type <= CYCLE_NONE;
      tcount    <= '0;
    end else begin
      tcount    <= tcount_upd;
    end
  end

endmodule

// File: rtl/z80fi_insn_recorder.sv
// Collects one retired instruction's bytes, M-cycle slots and IP before/after,
// and emits them as a single-cycle z80fi_valid packet.
//   state     | meaning
//   ST_IDLE   | no instruction open
//   ST_ACTIVE | accumulating the current instruction
module z80fi_insn_recorder
  import z80fi_insn_recorder_pkg::*;
#(
  parameter int MAX_BYTES   = 4,
  parameter int MAX_MCYCLES = 5,
  parameter int TC_W        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mc_start,
  input  logic [CYCLE_W-1:0]     mc_type,
  input  logic                   t_tick,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   insn_end,
  input  logic [15:0]            ip_cur,
  output logic                   z80fi_valid,
  output logic [8*MAX_BYTES-1:0] z80fi_insn,
  output logic [LEN_W-1:0]       z80fi_insn_len,
  output logic [CYCLE_W-1:0]     z80fi_mcycle_type1,
  output logic [CYCLE_W-1:0]     z80fi_mcycle_type2,
  output logic [CYCLE_W-1:0]     z80fi_mcycle_type3,
  output logic [CYCLE_W-1:0]     z80fi_mcycle_type4,
  output logic [CYCLE_W-1:0]     z80fi_mcycle_type5,
  output logic [TC_W-1:0]        z80fi_tcycles1,
  output logic [TC_W-1:0]        z80fi_tcycles2,
  output logic [TC_W-1:0]        z80fi_tcycles3,
  output logic [TC_W-1:0]        z80fi_tcycles4,
  output logic [TC_W-1:0]        z80fi_tcycles5,
  output logic [15:0]            z80fi_reg_ip_in,
  output logic [15:0]            z80fi_reg_ip_out,
  output logic                   z80fi_rec_err
);

  rec_state_t state, state_nxt;
  logic open_insn, close_insn, advance, tick_en, byte_en;

  logic [8*MAX_BYTES-1:0] bytes_q, bytes_nxt;
  logic [LEN_W-1:0]       len_q, len_nxt;
  logic [IDX_W-1:0]       idx_q;
  logic [15:0]            ip_in_q;
  logic                   err_q, err_nxt, byte_ovf, mc_ovf;

  logic [NUM_SLOTS-1:0][CYCLE_W-1:0] slot_type;
  logic [NUM_SLOTS-1:0][TC_W-1:0]    slot_tc;

  logic [NUM_SLOTS-1:0][CYCLE_W-1:0] pkt_type;
  logic [NUM_SLOTS-1:0][TC_W-1:0]    pkt_tc;
  logic [15:0]                       ip_out_q;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (mc_start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (insn_end) state_nxt = mc_start ? ST_ACTIVE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    open_insn  = 1'b0;
    close_insn = 1'b0;
    advance    = 1'b0;
    tick_en    = 1'b0;
    byte_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        open_insn = mc_start;
        byte_en   = byte_valid && mc_start;
      end
      ST_ACTIVE: begin
        close_insn = insn_end;
        open_insn  = insn_end && mc_start;
        advance    = mc_start && !insn_end;
        tick_en    = t_tick;
        byte_en    = byte_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    bytes_nxt = bytes_q;
    len_nxt   = len_q;
    byte_ovf  = 1'b0;
    if (byte_en) begin
      if (len_q == LEN_W'(MAX_BYTES)) begin
        byte_ovf = 1'b1;
      end else begin
        bytes_nxt[8*len_q +: 8] = byte_data;
        len_nxt                 = len_q + 1'b1;
      end
    end
    mc_ovf  = advance && (idx_q >= IDX_W'(MAX_MCYCLES));
    err_nxt = err_q | byte_ovf | mc_ovf;
  end

  // idx_q parks at MAX_MCYCLES+1 once a slot is dropped so later ticks are discarded too
  always_ff @(posedge clk) begin
    if (reset) begin
      bytes_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ip_in_q <= '0;
      err_q   <= 1'b0;
    end else if (close_insn) begin
      bytes_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      idx_q   <= open_insn ? IDX_W'(1) : '0;
      ip_in_q <= open_insn ? ip_cur : '0;
    end else if (open_insn) begin
      bytes_q <= bytes_nxt;
      len_q   <= len_nxt;
      err_q   <= err_nxt;
      idx_q   <= IDX_W'(1);
      ip_in_q <= ip_cur;
    end else begin
      bytes_q <= bytes_nxt;
      len_q   <= len_nxt;
      err_q   <= err_nxt;
      if (advance && (idx_q <= IDX_W'(MAX_MCYCLES))) idx_q <= idx_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    if (i < MAX_MCYCLES) begin : g_used
      logic load_i, tick_i;
      assign load_i = (open_insn && (i == 0)) || (advance && (idx_q == IDX_W'(i)));
      assign tick_i = tick_en && (idx_q == IDX_W'(i + 1));
      z80fi_insn_recorder_mcycle_slot #(.TC_W(TC_W)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load_i),
        .clear      (close_insn),
        .tick       (tick_i),
        .type_in    (mc_type),
        .slot_type  (slot_type[i]),
        .tcount_upd (slot_tc[i])
      );
    end else begin : g_unused
      assign slot_type[i] = CYCLE_NONE;
      assign slot_tc[i]   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      z80fi_valid     <= 1'b0;
      z80fi_insn      <= '0;
      z80fi_insn_len  <= '0;
      z80fi_rec_err   <= 1'b0;
      z80fi_reg_ip_in <= '0;
      pkt_type        <= '0;
      pkt_tc          <= '0;
      ip_out_q        <= '0;
    end else begin
      z80fi_valid <= close_insn;
      if (close_insn) begin
        z80fi_insn      <= bytes_nxt;
        z80fi_insn_len  <= len_nxt;
        z80fi_rec_err   <= err_nxt;
        z80fi_reg_ip_in <= ip_in_q;
        pkt_type        <= slot_type;
        pkt_tc          <= slot_tc;
      end
      if (z80fi_valid) ip_out_q <= ip_cur;
    end
  end

  // ip_out reflects ip_cur of the valid clock itself, then holds until the next packet
  assign z80fi_reg_ip_out = z80fi_valid ? ip_cur : ip_out_q;

  assign z80fi_mcycle_type1 = pkt_type[0];
  assign z80fi_mcycle_type2 = pkt_type[1];
  assign z80fi_mcycle_type3 = pkt_type[2];
  assign z80fi_mcycle_type4 = pkt_type[3];
  assign z80fi_mcycle_type5 = pkt_type[4];
  assign z80fi_tcycles1     = pkt_tc[0];
  assign z80fi_tcycles2     = pkt_tc[1];
  assign z80fi_tcycles3     = pkt_tc[2];
  assign z80fi_tcycles4     = pkt_tc[3];
  assign z80fi_tcycles5     = pkt_tc[4];

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Bench for z80fi_insn_recorder: instructions are described as transactions (cycles, ticks, bytes),
// expanded into a per-clock stimulus table, and packets are predicted from the transaction itself.
module tb_z80fi_insn_recorder;
  import z80fi_insn_recorder_pkg::*;

  localparam int MAXC = 16000;
  localparam int MAXP = 400;

  logic        clk = 1'b0;
  logic        reset, mc_start, t_tick, byte_valid, insn_end;
  logic [2:0]  mc_type;
  logic [7:0]  byte_data;
  logic [15:0] ip_cur;

  logic        z80fi_valid, z80fi_rec_err;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [2:0]  z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4, z80fi_mcycle_type5;
  logic [3:0]  z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4, z80fi_tcycles5;
  logic [15:0] z80fi_reg_ip_in, z80fi_reg_ip_out;

  z80fi_insn_recorder dut (
    .clk(clk), .reset(reset), .mc_start(mc_start), .mc_type(mc_type), .t_tick(t_tick),
    .byte_valid(byte_valid), .byte_data(byte_data), .insn_end(insn_end), .ip_cur(ip_cur),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_mcycle_type1(z80fi_mcycle_type1), .z80fi_mcycle_type2(z80fi_mcycle_type2),
    .z80fi_mcycle_type3(z80fi_mcycle_type3), .z80fi_mcycle_type4(z80fi_mcycle_type4),
    .z80fi_mcycle_type5(z80fi_mcycle_type5),
    .z80fi_tcycles1(z80fi_tcycles1), .z80fi_tcycles2(z80fi_tcycles2), .z80fi_tcycles3(z80fi_tcycles3),
    .z80fi_tcycles4(z80fi_tcycles4), .z80fi_tcycles5(z80fi_tcycles5),
    .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_ip_out(z80fi_reg_ip_out), .z80fi_rec_err(z80fi_rec_err)
  );

  always #5 clk = ~clk;

  logic [2:0] o_type [5];
  logic [3:0] o_tc   [5];
  assign o_type[0] = z80fi_mcycle_type1;
  assign o_type[1] = z80fi_mcycle_type2;
  assign o_type[2] = z80fi_mcycle_type3;
  assign o_type[3] = z80fi_mcycle_type4;
  assign o_type[4] = z80fi_mcycle_type5;
  assign o_tc[0]   = z80fi_tcycles1;
  assign o_tc[1]   = z80fi_tcycles2;
  assign o_tc[2]   = z80fi_tcycles3;
  assign o_tc[3]   = z80fi_tcycles4;
  assign o_tc[4]   = z80fi_tcycles5;

  // per-clock stimulus table
  bit          s_rst [MAXC], s_mc [MAXC], s_tick [MAXC], s_byte [MAXC], s_end [MAXC], s_chkrst [MAXC];
  logic [2:0]  s_type [MAXC];
  logic [7:0]  s_data [MAXC];
  logic [15:0] s_ip [MAXC];
  int          pkt_at [MAXC];

  // expected packets
  logic [31:0] p_insn [MAXP];
  int          p_len [MAXP], p_err [MAXP], p_start [MAXP];
  logic [2:0]  p_type [MAXP][5];
  int          p_tc [MAXP][5];

  int ncl, npk, prev_end;
  int n_cmp, n_bad;

  // transaction under construction
  int         t_nmc, t_nb, t_abort, t_ipin, t_ipout;
  bit         t_merge, t_rst_end;
  logic [2:0] t_type [8];
  int         t_ticks [8];
  logic [7:0] t_bytes [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_clk();
    s_ip[ncl] = 16'($urandom);
    ncl++;
  endtask

  // idle clocks; optional stray strobes that an idle recorder must ignore
  task automatic gap(input int n, input bit stray);
    for (int g = 0; g < n; g++) begin
      new_clk();
      if (stray && ($urandom_range(0, 2) == 0)) begin
        s_tick[ncl-1] = 1'($urandom);
        s_end[ncl-1]  = 1'($urandom);
        s_byte[ncl-1] = 1'($urandom);
        s_data[ncl-1] = 8'($urandom);
      end
    end
  endtask

  task automatic clr_t();
    t_merge = 0; t_rst_end = 0; t_abort = -1; t_ipin = -1; t_ipout = -1;
    t_nmc = 1; t_nb = 1;
    for (int k = 0; k < 8; k++) begin
      t_type[k]  = CYCLE_M1;
      t_ticks[k] = 4;
      t_bytes[k] = 8'($urandom);
    end
  endtask

  task automatic emit();
    int  lfull, start, j, nb, bl, bi, last, ncap;
    bit  merged, done;
    merged = t_merge && (prev_end >= 0);
    lfull = 0;
    for (int k = 0; k < t_nmc; k++) lfull += 1 + t_ticks[k];
    start = merged ? prev_end : ncl;
    nb = t_nb;
    if (nb > lfull - (merged ? 1 : 0)) nb = lfull - (merged ? 1 : 0);
    bl = nb; bi = 0; j = 0; done = 0;
    for (int k = 0; k < t_nmc && !done; k++) begin
      for (int q = 0; q <= t_ticks[k] && !done; q++) begin
        int c;
        c = start + j;
        if (c == ncl) new_clk();
        if (q == 0) begin
          s_mc[c] = 1; s_type[c] = t_type[k];
        end else begin
          s_tick[c] = 1;
        end
        if (bl > 0 && !(merged && j == 0) && (bl >= lfull - j || $urandom_range(0, 1) == 1)) begin
          s_byte[c] = 1; s_data[c] = t_bytes[bi]; bi++; bl--;
        end
        if (j == t_abort) begin
          s_rst[c] = 1; done = 1;
        end
        j++;
      end
    end
    last = start + j - 1;
    if (done || t_rst_end) begin
      if (t_rst_end) begin
        s_end[last] = 1; s_rst[last] = 1;
      end
      prev_end = -1;
      new_clk();
      s_chkrst[last+1] = 1;
      return;
    end
    s_end[last] = 1;
    ncap = (nb > 4) ? 4 : nb;
    p_insn[npk] = '0;
    for (int b = 0; b < ncap; b++) p_insn[npk] |= 32'(t_bytes[b]) << (8 * b);
    p_len[npk]   = ncap;
    p_err[npk]   = (nb > 4 || t_nmc > 5) ? 1 : 0;
    p_start[npk] = start;
    for (int k = 0; k < 5; k++) begin
      p_type[npk][k] = (k < t_nmc) ? t_type[k] : CYCLE_NONE;
      p_tc[npk][k]   = (k < t_nmc) ? ((t_ticks[k] > 15) ? 15 : t_ticks[k]) : 0;
    end
    pkt_at[last+1] = npk;
    npk++;
    prev_end = last;
    if (t_ipin >= 0) s_ip[start] = 16'(t_ipin);
    if (t_ipout >= 0) begin
      if (ncl == last + 1) new_clk();
      s_ip[last+1] = 16'(t_ipout);
    end
  endtask

  initial begin
    int p;
    n_cmp = 0; n_bad = 0; ncl = 0; npk = 0; prev_end = -1;
    for (int i = 0; i < MAXC; i++) begin
      s_rst[i] = 0; s_mc[i] = 0; s_tick[i] = 0; s_byte[i] = 0; s_end[i] = 0; s_chkrst[i] = 0;
      s_type[i] = '0; s_data[i] = '0; s_ip[i] = '0; pkt_at[i] = -1;
    end

    new_clk(); s_rst[0] = 1;
    new_clk(); s_rst[1] = 1;
    s_chkrst[1] = 1; s_chkrst[2] = 1;
    gap(1, 0);

    // LD IX,nn
    clr_t();
    t_nmc = 4;
    t_type[0] = CYCLE_M1; t_type[1] = CYCLE_M1; t_type[2] = CYCLE_RDWR_MEM; t_type[3] = CYCLE_RDWR_MEM;
    t_ticks[0] = 4; t_ticks[1] = 4; t_ticks[2] = 3; t_ticks[3] = 3;
    t_nb = 4; t_bytes[0] = 8'hDD; t_bytes[1] = 8'h21; t_bytes[2] = 8'h34; t_bytes[3] = 8'h12;
    t_ipin = 16'h0100; t_ipout = 16'h0104;
    emit(); gap(2, 0);

    // two NOPs back to back
    clr_t(); t_bytes[0] = 8'h00; emit();
    clr_t(); t_bytes[0] = 8'h00; t_merge = 1; emit();
    gap(2, 0);

    // byte overflow
    clr_t(); t_nmc = 2; t_type[1] = CYCLE_RDWR_MEM; t_ticks[1] = 3; t_nb = 5;
    for (int k = 0; k < 5; k++) t_bytes[k] = 8'(k + 1);
    emit(); gap(1, 0);

    // six machine cycles
    clr_t(); t_nmc = 6; t_nb = 2;
    for (int k = 0; k < 6; k++) begin t_type[k] = 3'(k + 1); t_ticks[k] = 3; end
    emit(); gap(1, 0);

    // T-counter saturation
    clr_t(); t_ticks[0] = 20; emit(); gap(1, 0);

    // reset mid-instruction, then a one-byte instruction
    clr_t(); t_nmc = 3; t_nb = 3; t_ticks[0] = 3; t_ticks[1] = 3; t_ticks[2] = 3; t_abort = 6;
    emit(); gap(1, 0);
    clr_t(); t_bytes[0] = 8'hA5; emit(); gap(1, 0);

    // reset on the insn_end clock
    clr_t(); t_ticks[0] = 3; t_rst_end = 1; emit(); gap(1, 0);

    // randomized instruction stream
    for (int n = 0; n < 220 && ncl < MAXC - 200 && npk < MAXP - 2; n++) begin
      int l;
      clr_t();
      t_nmc = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(1, 5);
      l = 0;
      for (int k = 0; k < t_nmc; k++) begin
        t_type[k]  = 3'($urandom_range(1, 7));
        t_ticks[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 6);
        l += 1 + t_ticks[k];
      end
      t_nb = $urandom_range(1, 6);
      t_merge = ($urandom_range(0, 9) < 4);
      if (l >= 3 && $urandom_range(0, 99) < 8) t_abort = $urandom_range(1, l - 2);
      else if ($urandom_range(0, 99) < 4) t_rst_end = 1;
      if (!t_merge || prev_end < 0) gap($urandom_range(0, 2), 1);
      emit();
    end
    gap(3, 0);

    reset = 1; mc_start = 0; mc_type = 0; t_tick = 0; byte_valid = 0; byte_data = 0; insn_end = 0; ip_cur = 0;
    for (int i = 0; i < ncl; i++) begin
      @(negedge clk);
      reset = s_rst[i]; mc_start = s_mc[i]; mc_type = s_type[i]; t_tick = s_tick[i];
      byte_valid = s_byte[i]; byte_data = s_data[i]; insn_end = s_end[i]; ip_cur = s_ip[i];
      #1;
      if (i >= 1) check("valid", 32'(z80fi_valid), 32'(pkt_at[i] >= 0));
      if (pkt_at[i] >= 0) begin
        p = pkt_at[i];
        check($sformatf("pkt%0d insn", p), z80fi_insn, p_insn[p]);
        check($sformatf("pkt%0d len", p), 32'(z80fi_insn_len), 32'(p_len[p]));
        check($sformatf("pkt%0d err", p), 32'(z80fi_rec_err), 32'(p_err[p]));
        check($sformatf("pkt%0d ip_in", p), 32'(z80fi_reg_ip_in), 32'(s_ip[p_start[p]]));
        check($sformatf("pkt%0d ip_out", p), 32'(z80fi_reg_ip_out), 32'(s_ip[i]));
        for (int k = 0; k < 5; k++) begin
          check($sformatf("pkt%0d type%0d", p, k + 1), 32'(o_type[k]), 32'(p_type[p][k]));
          check($sformatf("pkt%0d tcycles%0d", p, k + 1), 32'(o_tc[k]), 32'(p_tc[p][k]));
        end
      end
      if (s_chkrst[i]) begin
        check("rst insn", z80fi_insn, 32'h0);
        check("rst len", 32'(z80fi_insn_len), 32'h0);
        check("rst err", 32'(z80fi_rec_err), 32'h0);
        check("rst ip_in", 32'(z80fi_reg_ip_in), 32'h0);
        check("rst ip_out", 32'(z80fi_reg_ip_out), 32'h0);
        check("rst type1", 32'(z80fi_mcycle_type1), 32'(CYCLE_NONE));
        check("rst tcycles1", 32'(z80fi_tcycles1), 32'h0);
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
